// File: rtl/sv_buffer_pkg.sv
// ----------------------------------------------------------------------------
// sv_buffer_pkg
// Shared constants and helpers for the buffer subsystem.
//   OSTAGE_DEPTH   : entries in the controller's output stage (head + skid)
//   MEM_RD_LATENCY : cycles from RAM read strobe to valid read data
//   ptr_width()    : address width needed for a ring of a given depth
// ----------------------------------------------------------------------------
package sv_buffer_pkg;

   localparam int OSTAGE_DEPTH   = 2;
   localparam int MEM_RD_LATENCY = 1;

   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/ring_buffer_ctrl_ring_ptr.sv
// ----------------------------------------------------------------------------
// ring_ptr
// Increment-only wrap-around pointer for a ring of DEPTH entries
// (DEPTH need not be a power of two).
//   clk   : clock
//   rst_n : asynchronous reset, active-high
//   clr   : synchronous clear to 0 (wins over adv)
//   adv   : advance by one, wrapping DEPTH-1 -> 0
//   ptr   : current pointer value
// ----------------------------------------------------------------------------
module ring_ptr
   import sv_buffer_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     adv,
   output logic [$clog2(DEPTH)-1:0] ptr
);

   localparam int            PW   = ptr_width(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   // Explicit compare against the last slot so non-power-of-two depths wrap
   // correctly instead of relying on natural binary overflow.
   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (adv) begin
         ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/ring_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// ring_buffer_ctrl
// Sequences a 1-write/1-read synchronous RAM (1-cycle read latency) as a
// circular buffer with ready/valid streams on both sides and a 2-entry
// output stage (head + skid) so the consumer sees registered data.
//   clk, rst_n             : clock, asynchronous active-high reset
//   flush                  : synchronous clear of all contents
//   in_valid/in_ready/in_data    : producer stream
//   out_valid/out_ready/out_data : consumer stream (head entry)
//   mem_wr_en/addr/data    : RAM write port
//   mem_rd_en/addr, mem_rd_data : RAM read port, data one cycle after strobe
//   level                  : entries held in RAM + in flight + output stage
// ----------------------------------------------------------------------------
module ring_buffer_ctrl
   import sv_buffer_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_WIDTH-1:0]        in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         mem_wr_en,
   output logic [$clog2(DEPTH)-1:0]     mem_wr_addr,
   output logic [DATA_WIDTH-1:0]        mem_wr_data,
   output logic                         mem_rd_en,
   output logic [$clog2(DEPTH)-1:0]     mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]        mem_rd_data,
   output logic [$clog2(DEPTH+2):0]     level
);

   localparam int            PW       = ptr_width(DEPTH);
   localparam int            CW       = $clog2(DEPTH + 1);
   localparam int            LW       = $clog2(DEPTH + 2) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [CW-1:0]         ram_cnt_q,    ram_cnt_d;
   logic                  rd_pend_q,    rd_pend_d;
   logic                  head_valid_q, head_valid_d;
   logic [DATA_WIDTH-1:0] head_data_q,  head_data_d;
   logic                  skid_valid_q, skid_valid_d;
   logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
   logic [LW-1:0]         level_q,      level_d;

   logic          push;
   logic          pop;
   logic          rd_issue;
   logic [2:0]    stage_occ;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // in_ready depends only on registered RAM occupancy (plus reset/flush
   // gating), so there is no combinational path from out_ready.
   assign in_ready = !rst_n && !flush && (ram_cnt_q != FULL_CNT);
   assign push     = in_valid && in_ready;
   assign pop      = head_valid_q && out_ready && !flush;

   // A read may only issue if its data is guaranteed a slot when it lands:
   // stage entries plus the read already in flight, less the one leaving.
   assign stage_occ = 3'(head_valid_q) + 3'(skid_valid_q) + 3'(rd_pend_q);
   assign rd_issue  = !rst_n && !flush && (ram_cnt_q != '0)
                      && (stage_occ < (3'(OSTAGE_DEPTH) + 3'(pop)));

   ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .adv   (push),
      .ptr   (wr_ptr)
   );

   ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .adv   (rd_issue),
      .ptr   (rd_ptr)
   );

   // Output stage update: first apply the pop (skid slides into head), then
   // land returning RAM data in the first free slot of the post-pop stage.
   // The skid is only ever occupied behind a valid head, which keeps order.
   // Flush overrides everything and drops any read data arriving this cycle.
   always_comb begin
      ram_cnt_d    = ram_cnt_q + CW'(push) - CW'(rd_issue);
      rd_pend_d    = rd_issue;
      head_valid_d = head_valid_q;
      head_data_d  = head_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;

      if (pop) begin
         head_valid_d = skid_valid_q;
         head_data_d  = skid_data_q;
         skid_valid_d = 1'b0;
      end

      if (rd_pend_q) begin
         if (!head_valid_d) begin
            head_valid_d = 1'b1;
            head_data_d  = mem_rd_data;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = mem_rd_data;
         end
      end

      if (flush) begin
         ram_cnt_d    = '0;
         rd_pend_d    = 1'b0;
         head_valid_d = 1'b0;
         head_data_d  = '0;
         skid_valid_d = 1'b0;
         skid_data_d  = '0;
      end

      level_d = LW'(ram_cnt_d) + LW'(rd_pend_d) + LW'(head_valid_d) + LW'(skid_valid_d);
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         ram_cnt_q    <= '0;
         rd_pend_q    <= 1'b0;
         head_valid_q <= 1'b0;
         head_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         level_q      <= '0;
      end else begin
         ram_cnt_q    <= ram_cnt_d;
         rd_pend_q    <= rd_pend_d;
         head_valid_q <= head_valid_d;
         head_data_q  <= head_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         level_q      <= level_d;
      end
   end

   assign mem_wr_en   = push;
   assign mem_wr_addr = wr_ptr;
   assign mem_wr_data = in_data;
   assign mem_rd_en   = rd_issue;
   assign mem_rd_addr = rd_ptr;
   assign out_valid   = head_valid_q;
   assign out_data    = head_data_q;
   assign level       = level_q;

endmodule

// File: tb/tb_ring_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ring_buffer_ctrl
// Directed bench for ring_buffer_ctrl (DEPTH=8, DATA_WIDTH=32) with a
// behavioural 1-cycle-latency RAM, an in-order scoreboard of accepted words
// and a small occupancy model built from the observed port activity.
// ----------------------------------------------------------------------------
module tb_ring_buffer_ctrl;

   localparam int DEPTH = 8;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          mem_wr_en;
   logic [2:0]    mem_wr_addr;
   logic [DW-1:0] mem_wr_data;
   logic          mem_rd_en;
   logic [2:0]    mem_rd_addr;
   logic [DW-1:0] mem_rd_data;
   logic [4:0]    level;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] exp_q[$];
   int            push_cnt = 0;
   int            pop_cnt  = 0;
   int            stage_m  = 0;
   int            stage_nx = 0;
   bit            rd_pend_m  = 1'b0;
   bit            rd_pend_nx = 1'b0;
   logic [DW-1:0] ram [DEPTH];

   ring_buffer_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .level       (level)
   );

   always #5 clk = ~clk;

   // Behavioural synchronous RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic vld, input logic [DW-1:0] data,
                                input logic rdy, input logic fl);
      in_valid  = vld;
      in_data   = data;
      out_ready = rdy;
      flush     = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Mid-cycle monitor: scoreboard accepted/delivered words and check the
   // issue rule against an occupancy model derived from observed strobes.
   always @(negedge clk) begin
      logic pop_now;
      if (rst_n) begin
         stage_nx   = 0;
         rd_pend_nx = 1'b0;
      end else if (flush) begin
         stage_nx   = 0;
         rd_pend_nx = 1'b0;
      end else begin
         pop_now = out_valid && out_ready;
         checkOutput("ovalid_vs_model", out_valid, stage_m != 0);
         if (mem_rd_en)
            checkOutput("issue_room", (stage_m + int'(rd_pend_m) - int'(pop_now)) < 2, 1);
         if (pop_now) begin
            pop_cnt++;
            checkOutput("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) checkOutput("sb_order", out_data, exp_q.pop_front());
         end
         if (in_valid && in_ready) begin
            push_cnt++;
            exp_q.push_back(in_data);
         end
         stage_nx   = stage_m + int'(rd_pend_m) - int'(pop_now);
         rd_pend_nx = mem_rd_en;
      end
   end

   always @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         stage_m   <= 0;
         rd_pend_m <= 1'b0;
      end else begin
         stage_m   <= stage_nx;
         rd_pend_m <= rd_pend_nx;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int w;

      // ---------------- reset held ----------------
      tick();
      applyStimulus(1'b1, 32'h1234, 1'b1, 1'b0);
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_wr_en", mem_wr_en, 0);
      checkOutput("rst_rd_en", mem_rd_en, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_level", level, 0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      rst_n = 1'b0;

      // ---------------- single entry latency ----------------
      tick();
      applyStimulus(1'b1, 32'hA5, 1'b1, 1'b0);
      checkOutput("t1_in_ready", in_ready, 1);
      checkOutput("t1_wr_en", mem_wr_en, 1);
      checkOutput("t1_wr_addr", mem_wr_addr, 0);
      checkOutput("t1_wr_data", mem_wr_data, 32'hA5);
      checkOutput("t1_c0_rd_en", mem_rd_en, 0);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("t1_c1_rd_en", mem_rd_en, 1);
      checkOutput("t1_c1_rd_addr", mem_rd_addr, 0);
      checkOutput("t1_c1_level", level, 1);
      checkOutput("t1_c1_out_valid", out_valid, 0);
      tick();
      checkOutput("t1_c2_out_valid", out_valid, 0);
      checkOutput("t1_c2_rd_en", mem_rd_en, 0);
      tick();
      checkOutput("t1_c3_out_valid", out_valid, 1);
      checkOutput("t1_c3_out_data", out_data, 32'hA5);
      tick();
      checkOutput("t1_c4_level", level, 0);
      checkOutput("t1_c4_out_valid", out_valid, 0);

      // ---------------- fill with consumer stalled ----------------
      n = 0;
      for (int c = 0; c < 14; c++) begin
         tick();
         applyStimulus(1'b1, 32'h100 + n, 1'b0, 1'b0);
         if (in_ready) n++;
      end
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("t2_accepted", n, 10);
      checkOutput("t2_level_full", level, 10);
      checkOutput("t2_in_ready", in_ready, 0);
      checkOutput("t2_rd_en_full", mem_rd_en, 0);
      checkOutput("t2_head", out_data, 32'h100);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0);
         checkOutput("t2_drain_valid", out_valid, 1);
         checkOutput("t2_drain_data", out_data, 32'h100 + i);
         tick();
      end
      checkOutput("t2_empty_valid", out_valid, 0);
      checkOutput("t2_empty_level", level, 0);

      // ---------------- flush idle buffer: pointers back to 0 ----------------
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("fl_wr_ptr", mem_wr_addr, 0);
      checkOutput("fl_rd_ptr", mem_rd_addr, 0);
      tick();

      // ---------------- streaming with wrap-around ----------------
      for (int c = 0; c < 24; c++) begin
         applyStimulus(c < 20, 32'h200 + c, 1'b1, 1'b0);
         if (c < 20) begin
            checkOutput("t3_in_ready", in_ready, 1);
            checkOutput("t3_wr_addr", mem_wr_addr, c % 8);
         end
         checkOutput("t3_rd_en", mem_rd_en, (c >= 1) && (c <= 20));
         if ((c >= 1) && (c <= 20)) checkOutput("t3_rd_addr", mem_rd_addr, (c - 1) % 8);
         checkOutput("t3_out_valid", out_valid, (c >= 3) && (c <= 22));
         if ((c >= 3) && (c <= 22)) checkOutput("t3_out_data", out_data, 32'h200 + c - 3);
         tick();
      end

      // ---------------- random backpressure ----------------
      for (int c = 0; c < 150; c++) begin
         applyStimulus(1'($urandom_range(0, 1)), 32'h300 + c, 1'($urandom_range(0, 1)), 1'b0);
         tick();
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      w = 0;
      while (level != 0 && w < 40) begin
         tick();
         w++;
      end
      checkOutput("t4_drained", level, 0);
      checkOutput("t4_no_loss", pop_cnt, push_cnt);

      // ---------------- flush with a read in flight ----------------
      tick();
      applyStimulus(1'b1, 32'hC0DE, 1'b0, 1'b0);
      checkOutput("t5_wr_en", mem_wr_en, 1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("t5_rd_issue", mem_rd_en, 1);
      tick();
      applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b1);
      checkOutput("t5_fl_in_ready", in_ready, 0);
      checkOutput("t5_fl_wr_en", mem_wr_en, 0);
      checkOutput("t5_fl_rd_en", mem_rd_en, 0);
      tick();
      exp_q.delete();
      applyStimulus(1'b1, 32'h77, 1'b1, 1'b0);
      checkOutput("t5_out_valid", out_valid, 0);
      checkOutput("t5_level", level, 0);
      checkOutput("t5_wr_addr", mem_wr_addr, 0);
      checkOutput("t5_in_ready", in_ready, 1);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("t5_rd_en", mem_rd_en, 1);
      checkOutput("t5_rd_addr", mem_rd_addr, 0);
      tick();
      checkOutput("t5_c5_valid", out_valid, 0);
      tick();
      checkOutput("t5_c6_valid", out_valid, 1);
      checkOutput("t5_c6_data", out_data, 32'h77);
      tick();
      checkOutput("t5_c7_level", level, 0);

      // ---------------- asynchronous reset mid-stream ----------------
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, 32'h500 + c, 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("t6_level5", level, 5);
      checkOutput("t6_pre_valid", out_valid, 1);
      checkOutput("t6_pre_data", out_data, 32'h500);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      #1;
      checkOutput("t6_rst_valid", out_valid, 0);
      checkOutput("t6_rst_level", level, 0);
      checkOutput("t6_rst_in_ready", in_ready, 0);
      checkOutput("t6_rst_rd_en", mem_rd_en, 0);
      rst_n = 1'b0;
      tick();
      applyStimulus(1'b1, 32'h55, 1'b1, 1'b0);
      checkOutput("t6_wr_addr", mem_wr_addr, 0);
      checkOutput("t6_level0", level, 0);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("t6_rd_en", mem_rd_en, 1);
      checkOutput("t6_rd_addr", mem_rd_addr, 0);
      tick();
      tick();
      checkOutput("t6_out_valid", out_valid, 1);
      checkOutput("t6_out_data", out_data, 32'h55);
      tick();
      checkOutput("t6_final_level", level, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
